// File: rtl/merc16_control_fsm_if.sv
// Control bundle between the MERC-16 control FSM (master) and the
// PC/memory/decode/ALU datapath (slave).
interface merc16_control_fsm_if;
    logic [15:0] Instruction;
    logic        EQ;
    logic        GR;
    logic        LT;
    logic        WritePC;
    logic        InstData;
    logic        WriteMemory;
    logic        WriteIR;
    logic        WriteRegister;
    logic [1:0]  RegData;
    logic [1:0]  RegDest;
    logic [1:0]  RsRd;
    logic        RsRt;
    logic        ZE_SE;
    logic        ALU_SrcA;
    logic [1:0]  ALU_SrcB;
    logic        UpperLower;
    logic [2:0]  ALU_Op;
    logic [1:0]  PC_Src;
    logic        Instr_Done;
    logic        Halted;

    modport master (
        input  Instruction, EQ, GR, LT,
        output WritePC, InstData, WriteMemory, WriteIR, WriteRegister,
               RegData, RegDest, RsRd, RsRt, ZE_SE, ALU_SrcA, ALU_SrcB,
               UpperLower, ALU_Op, PC_Src, Instr_Done, Halted
    );

    modport slave (
        output Instruction, EQ, GR, LT,
        input  WritePC, InstData, WriteMemory, WriteIR, WriteRegister,
               RegData, RegDest, RsRd, RsRt, ZE_SE, ALU_SrcA, ALU_SrcB,
               UpperLower, ALU_Op, PC_Src, Instr_Done, Halted
    );
endinterface

// File: rtl/merc16_control_fsm.sv
// Multi-cycle MERC-16 control unit: encoded Moore FSM driving every datapath
// strobe and select; only WritePC in BR_CMP follows the comparator flags directly.
module merc16_control_fsm #(
    parameter logic [2:0] BR_CMP_OP   = 3'd7,
    parameter bit         ILLEGAL_NOP = 1'b1
) (
    input logic                  Clock,
    input logic                  Reset,
    merc16_control_fsm_if.master bus
);
    typedef enum logic [4:0] {
        FETCH, PC_INC, PC_WR, EXEC, WB_ALU, WB_IMM, MEM_ADDR, MEM_RD, WB_MEM,
        MEM_WR, JUMP, JR_EXEC, JR_WR, CALL, BR_TGT, BR_CMP, HALT
    } state_t;

    state_t     state;
    state_t     nextState;
    logic [4:0] opcode;
    logic       isRType;
    logic       isImmAlu;
    logic       isBranch;
    logic       isStore;
    logic       branchTaken;
    logic [2:0] execOp;
    logic [1:0] rsRdSel;
    logic       rsRtSel;
    logic       unusedFields;

    assign opcode       = bus.Instruction[15:11];
    assign unusedFields = ^bus.Instruction[10:0];
    assign isRType      = (opcode <= 5'h05);
    assign isImmAlu     = (opcode >= 5'h06) && (opcode <= 5'h08);
    assign isBranch     = (opcode >= 5'h10) && (opcode <= 5'h15);
    assign isStore      = (opcode == 5'h0C);

    // Instruction-class decode: register-file selects, EXEC ALU function, branch condition.
    always_comb begin
        rsRdSel     = 2'd0;
        rsRtSel     = 1'b0;
        execOp      = 3'd0;
        branchTaken = 1'b0;
        if (isRType || isBranch) begin
            rsRtSel = 1'b1;
        end else if (isImmAlu || opcode == 5'h0B) begin
            rsRdSel = 2'd1;
        end else if (isStore || opcode == 5'h0E) begin
            rsRdSel = 2'd2;
        end
        case (opcode)
            5'h00, 5'h01, 5'h02, 5'h03, 5'h04: execOp = opcode[2:0];
            5'h05:   execOp = 3'd7;
            5'h07:   execOp = 3'd5;
            5'h08:   execOp = 3'd6;
            default: execOp = 3'd0;
        endcase
        case (opcode)
            5'h10:   branchTaken = bus.EQ;
            5'h11:   branchTaken = ~bus.EQ;
            5'h12:   branchTaken = bus.LT;
            5'h13:   branchTaken = bus.GR;
            5'h14:   branchTaken = bus.LT | bus.EQ;
            5'h15:   branchTaken = bus.GR | bus.EQ;
            default: branchTaken = 1'b0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) state <= FETCH;
        else       state <= nextState;
    end

    // Outputs stay forced low for the whole Reset cycle, whatever state was in flight.
    always_comb begin
        nextState         = state;
        bus.WritePC       = 1'b0;
        bus.InstData      = 1'b0;
        bus.WriteMemory   = 1'b0;
        bus.WriteIR       = 1'b0;
        bus.WriteRegister = 1'b0;
        bus.RegData       = 2'd0;
        bus.RegDest       = 2'd0;
        bus.RsRd          = 2'd0;
        bus.RsRt          = 1'b0;
        bus.ZE_SE         = 1'b0;
        bus.ALU_SrcA      = 1'b0;
        bus.ALU_SrcB      = 2'd0;
        bus.UpperLower    = 1'b0;
        bus.ALU_Op        = 3'd0;
        bus.PC_Src        = 2'd0;
        bus.Instr_Done    = 1'b0;
        bus.Halted        = 1'b0;
        if (!Reset) begin
            if (state != FETCH && state != PC_INC && state != HALT) begin
                bus.RsRd = rsRdSel;
                bus.RsRt = rsRtSel;
            end
            case (state)
                FETCH: begin
                    bus.WriteIR = 1'b1;
                    nextState   = PC_INC;
                end
                PC_INC: begin
                    bus.ALU_SrcB = 2'd1;
                    nextState    = PC_WR;
                end
                PC_WR: begin
                    bus.PC_Src  = 2'd1;
                    bus.WritePC = 1'b1;
                    if (opcode <= 5'h08)      nextState = EXEC;
                    else if (opcode <= 5'h0A) nextState = WB_IMM;
                    else if (opcode <= 5'h0C) nextState = MEM_ADDR;
                    else if (opcode == 5'h0D) nextState = JUMP;
                    else if (opcode == 5'h0E) nextState = JR_EXEC;
                    else if (opcode == 5'h0F) nextState = CALL;
                    else if (isBranch)        nextState = BR_TGT;
                    else begin
                        bus.Instr_Done = ILLEGAL_NOP;
                        nextState      = ILLEGAL_NOP ? FETCH : HALT;
                    end
                end
                EXEC: begin
                    bus.ALU_SrcA = 1'b1;
                    bus.ALU_SrcB = isRType ? 2'd0 : 2'd3;
                    bus.ALU_Op   = execOp;
                    bus.ZE_SE    = (opcode == 5'h06);
                    nextState    = WB_ALU;
                end
                WB_ALU: begin
                    bus.RegData       = 2'd1;
                    bus.WriteRegister = 1'b1;
                    bus.Instr_Done    = 1'b1;
                    nextState         = FETCH;
                end
                WB_IMM: begin
                    bus.RegData       = 2'd3;
                    bus.RegDest       = 2'd1;
                    bus.UpperLower    = (opcode == 5'h0A);
                    bus.WriteRegister = 1'b1;
                    bus.Instr_Done    = 1'b1;
                    nextState         = FETCH;
                end
                MEM_ADDR: begin
                    bus.ALU_SrcA = 1'b1;
                    if (isStore) begin
                        bus.ALU_SrcB = 2'd3;
                        bus.ZE_SE    = 1'b1;
                        nextState    = MEM_WR;
                    end else begin
                        bus.ALU_SrcB = 2'd2;
                        nextState    = MEM_RD;
                    end
                end
                MEM_RD: begin
                    bus.InstData = 1'b1;
                    nextState    = WB_MEM;
                end
                WB_MEM: begin
                    bus.InstData      = 1'b1;
                    bus.WriteRegister = 1'b1;
                    bus.Instr_Done    = 1'b1;
                    nextState         = FETCH;
                end
                MEM_WR: begin
                    bus.InstData    = 1'b1;
                    bus.WriteMemory = 1'b1;
                    bus.Instr_Done  = 1'b1;
                    nextState       = FETCH;
                end
                JUMP: begin
                    bus.WritePC    = 1'b1;
                    bus.Instr_Done = 1'b1;
                    nextState      = FETCH;
                end
                JR_EXEC: begin
                    bus.ALU_SrcA = 1'b1;
                    nextState    = JR_WR;
                end
                JR_WR: begin
                    bus.PC_Src     = 2'd1;
                    bus.WritePC    = 1'b1;
                    bus.Instr_Done = 1'b1;
                    nextState      = FETCH;
                end
                CALL: begin
                    bus.WritePC       = 1'b1;
                    bus.RegDest       = 2'd2;
                    bus.RegData       = 2'd2;
                    bus.WriteRegister = 1'b1;
                    bus.Instr_Done    = 1'b1;
                    nextState         = FETCH;
                end
                BR_TGT: begin
                    bus.ALU_SrcB = 2'd2;
                    nextState    = BR_CMP;
                end
                BR_CMP: begin
                    bus.ALU_SrcA   = 1'b1;
                    bus.ALU_Op     = BR_CMP_OP;
                    bus.PC_Src     = 2'd1;
                    bus.WritePC    = branchTaken;
                    bus.Instr_Done = 1'b1;
                    nextState      = FETCH;
                end
                HALT: begin
                    bus.Halted = 1'b1;
                    nextState  = HALT;
                end
                default: nextState = FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_merc16_control_fsm.sv
// Scoreboard bench for merc16_control_fsm: one DUT retiring illegal opcodes as
// no-ops, one parking in HALT, both checked cycle by cycle against a sequence model.
module tb_merc16_control_fsm;
    typedef struct packed {
        logic       WritePC;
        logic       InstData;
        logic       WriteMemory;
        logic       WriteIR;
        logic       WriteRegister;
        logic [1:0] RegData;
        logic [1:0] RegDest;
        logic [1:0] RsRd;
        logic       RsRt;
        logic       ZE_SE;
        logic       ALU_SrcA;
        logic [1:0] ALU_SrcB;
        logic       UpperLower;
        logic [2:0] ALU_Op;
        logic [1:0] PC_Src;
        logic       InstrDone;
        logic       Halted;
    } ctrl_t;

    typedef struct {
        ctrl_t a;
        ctrl_t b;
        int    op;
        int    cyc;
    } exp_t;

    logic  Clock = 1'b0;
    logic  Reset;
    ctrl_t actA;
    ctrl_t actB;
    exp_t  expQ[$];
    ctrl_t seq[$];
    bit    bHalted = 1'b0;
    int    total = 0;
    int    bad = 0;

    merc16_control_fsm_if busA ();
    merc16_control_fsm_if busB ();

    merc16_control_fsm #(.BR_CMP_OP(3'd7), .ILLEGAL_NOP(1'b1)) dutA (
        .Clock(Clock), .Reset(Reset), .bus(busA)
    );
    merc16_control_fsm #(.BR_CMP_OP(3'd7), .ILLEGAL_NOP(1'b0)) dutB (
        .Clock(Clock), .Reset(Reset), .bus(busB)
    );

    always #5 Clock = ~Clock;

    assign actA = {busA.WritePC, busA.InstData, busA.WriteMemory, busA.WriteIR,
                   busA.WriteRegister, busA.RegData, busA.RegDest, busA.RsRd,
                   busA.RsRt, busA.ZE_SE, busA.ALU_SrcA, busA.ALU_SrcB,
                   busA.UpperLower, busA.ALU_Op, busA.PC_Src, busA.Instr_Done,
                   busA.Halted};
    assign actB = {busB.WritePC, busB.InstData, busB.WriteMemory, busB.WriteIR,
                   busB.WriteRegister, busB.RegData, busB.RegDest, busB.RsRd,
                   busB.RsRt, busB.ZE_SE, busB.ALU_SrcA, busB.ALU_SrcB,
                   busB.UpperLower, busB.ALU_Op, busB.PC_Src, busB.Instr_Done,
                   busB.Halted};

    // Per-cycle control words an instruction should produce, built from the opcode table.
    task automatic buildSeq(input int op, input logic eq, input logic gr, input logic lt);
        ctrl_t c;
        ctrl_t s;
        int    aluOpOf [0:8] = '{0, 1, 2, 3, 4, 7, 0, 5, 6};
        logic  taken;
        seq.delete();
        s = '0;
        if (op <= 5 || (op >= 16 && op <= 21)) s.RsRt = 1'b1;
        else if (op == 6 || op == 7 || op == 8 || op == 11) s.RsRd = 2'd1;
        else if (op == 12 || op == 14) s.RsRd = 2'd2;
        c = '0; c.WriteIR = 1'b1; seq.push_back(c);
        c = '0; c.ALU_SrcB = 2'd1; seq.push_back(c);
        c = s; c.PC_Src = 2'd1; c.WritePC = 1'b1; c.InstrDone = (op >= 22);
        seq.push_back(c);
        if (op <= 8) begin
            c = s; c.ALU_SrcA = 1'b1; c.ALU_SrcB = (op <= 5) ? 2'd0 : 2'd3;
            c.ALU_Op = 3'(aluOpOf[op]); c.ZE_SE = (op == 6); seq.push_back(c);
            c = s; c.RegData = 2'd1; c.WriteRegister = 1'b1; c.InstrDone = 1'b1;
            seq.push_back(c);
        end else if (op == 9 || op == 10) begin
            c = s; c.RegData = 2'd3; c.RegDest = 2'd1; c.UpperLower = (op == 10);
            c.WriteRegister = 1'b1; c.InstrDone = 1'b1; seq.push_back(c);
        end else if (op == 11) begin
            c = s; c.ALU_SrcA = 1'b1; c.ALU_SrcB = 2'd2; seq.push_back(c);
            c = s; c.InstData = 1'b1; seq.push_back(c);
            c = s; c.InstData = 1'b1; c.WriteRegister = 1'b1; c.InstrDone = 1'b1;
            seq.push_back(c);
        end else if (op == 12) begin
            c = s; c.ALU_SrcA = 1'b1; c.ALU_SrcB = 2'd3; c.ZE_SE = 1'b1; seq.push_back(c);
            c = s; c.InstData = 1'b1; c.WriteMemory = 1'b1; c.InstrDone = 1'b1;
            seq.push_back(c);
        end else if (op == 13) begin
            c = s; c.WritePC = 1'b1; c.InstrDone = 1'b1; seq.push_back(c);
        end else if (op == 14) begin
            c = s; c.ALU_SrcA = 1'b1; seq.push_back(c);
            c = s; c.PC_Src = 2'd1; c.WritePC = 1'b1; c.InstrDone = 1'b1; seq.push_back(c);
        end else if (op == 15) begin
            c = s; c.WritePC = 1'b1; c.RegDest = 2'd2; c.RegData = 2'd2;
            c.WriteRegister = 1'b1; c.InstrDone = 1'b1; seq.push_back(c);
        end else if (op <= 21) begin
            case (op)
                16:      taken = eq;
                17:      taken = ~eq;
                18:      taken = lt;
                19:      taken = gr;
                20:      taken = lt | eq;
                default: taken = gr | eq;
            endcase
            c = s; c.ALU_SrcB = 2'd2; seq.push_back(c);
            c = s; c.ALU_SrcA = 1'b1; c.ALU_Op = 3'd7; c.PC_Src = 2'd1;
            c.WritePC = taken; c.InstrDone = 1'b1; seq.push_back(c);
        end
    endtask

    // keep > 0 cuts the instruction short after that many cycles (used before a reset).
    task automatic applyStimulus(input logic [15:0] instr, input logic eq, input logic gr,
                                 input logic lt, input int keep);
        exp_t e;
        int   n;
        int   op;
        op = int'(instr[15:11]);
        buildSeq(op, eq, gr, lt);
        busA.Instruction = instr; busA.EQ = eq; busA.GR = gr; busA.LT = lt;
        busB.Instruction = instr; busB.EQ = eq; busB.GR = gr; busB.LT = lt;
        n = (keep > 0 && keep < seq.size()) ? keep : seq.size();
        for (int i = 0; i < n; i++) begin
            e.a = seq[i];
            if (bHalted) begin
                e.b = '0;
                e.b.Halted = 1'b1;
            end else begin
                e.b = seq[i];
                if (op >= 22) e.b.InstrDone = 1'b0;
            end
            e.op  = op;
            e.cyc = i;
            expQ.push_back(e);
        end
        if (op >= 22 && n == 3) bHalted = 1'b1;
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic applyReset(input int cycles);
        exp_t e;
        Reset = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            e.a = '0; e.b = '0; e.op = -1; e.cyc = i;
            expQ.push_back(e);
        end
        bHalted = 1'b0;
        repeat (cycles) begin
            @(posedge Clock);
            #1;
        end
        Reset = 1'b0;
    endtask

    task automatic checkOutput(input string who, input int op, input int cyc,
                               input ctrl_t act, input ctrl_t req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s op=%0h cyc=%0d actual=%06h required=%06h",
                     who, op, cyc, act, req);
        end
    endtask

    always @(negedge Clock) begin
        exp_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("dutA", e.op, e.cyc, actA, e.a);
            checkOutput("dutB", e.op, e.cyc, actB, e.b);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [4:0]  op5;
        logic [15:0] instr;
        logic [2:0]  fl;
        Reset = 1'b1;
        busA.Instruction = '0; busA.EQ = 1'b0; busA.GR = 1'b0; busA.LT = 1'b0;
        busB.Instruction = '0; busB.EQ = 1'b0; busB.GR = 1'b0; busB.LT = 1'b0;
        @(posedge Clock);
        #1;
        applyReset(2);

        applyStimulus(16'h0000, 1'b1, 1'b0, 1'b0, 0);
        applyStimulus(16'h5800, 1'b0, 1'b1, 1'b0, 0);
        applyStimulus(16'h5800, 1'b0, 1'b0, 1'b1, 4);
        applyReset(3);

        // Every branch against each of the three comparator outcomes.
        for (int b = 16; b <= 21; b++) begin
            for (int p = 0; p < 3; p++) begin
                op5 = 5'(b);
                instr = {op5, 11'($urandom)};
                applyStimulus(instr, p == 0, p == 1, p == 2, 0);
            end
        end
        applyStimulus(16'h7800, 1'b0, 1'b0, 1'b0, 0);

        for (int o = 0; o <= 21; o++) begin
            op5 = 5'(o);
            fl = 3'($urandom);
            instr = {op5, 11'($urandom)};
            applyStimulus(instr, fl[0], fl[1], fl[2], 0);
        end

        applyStimulus(16'hB000, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(16'h0000, 1'b1, 1'b0, 1'b0, 0);
        applyStimulus(16'h6000, 1'b0, 1'b0, 1'b0, 0);
        applyReset(1);

        for (int k = 0; k < 200; k++) begin
            op5 = 5'($urandom_range(0, 31));
            fl = 3'($urandom);
            instr = {op5, 11'($urandom)};
            if ($urandom_range(0, 9) == 0) begin
                applyStimulus(instr, fl[0], fl[1], fl[2], int'($urandom_range(1, 5)));
                applyReset(int'($urandom_range(1, 3)));
            end else begin
                applyStimulus(instr, fl[0], fl[1], fl[2], 0);
            end
            if ($urandom_range(0, 15) == 0) applyReset(1);
        end

        @(posedge Clock);
        #1;
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain actual=%0d required=0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
